// File: rtl/shift_stage_ctrl.sv
// shift_stage_ctrl: sequential wrapper around the datapath's combinational
// barrel shifter. It takes one request over a valid/ready handshake,
// registers it onto the shifter inputs, captures the shifter output a cycle
// later and offers that result downstream over a second valid/ready
// handshake. Only one operation is in flight at a time.
module shift_stage_ctrl #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [SHW-1:0]   req_shift,
    output logic [WIDTH-1:0] sh_in,
    output logic [SHW-1:0]   sh_shift,
    input  logic [WIDTH-1:0] sh_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic [SHW-1:0]   res_shift,
    output logic             busy,
    output logic [CNTW-1:0]  op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] sh_in_q,     sh_in_d;
    logic [SHW-1:0]   sh_shift_q,  sh_shift_d;
    logic [WIDTH-1:0] res_data_q,  res_data_d;
    logic             res_zero_q,  res_zero_d;
    logic [SHW-1:0]   res_shift_q, res_shift_d;
    logic [CNTW-1:0]  op_count_q,  op_count_d;

    // Next-state, handshake outputs and register updates for the request/result FSM.
    always_comb begin
        state_d     = state_q;
        sh_in_d     = sh_in_q;
        sh_shift_d  = sh_shift_q;
        res_data_d  = res_data_q;
        res_zero_d  = res_zero_q;
        res_shift_d = res_shift_q;
        op_count_d  = op_count_q;
        req_ready   = 1'b0;
        res_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    sh_in_d    = req_data;
                    sh_shift_d = req_shift;
                    state_d    = CALC;
                end
            end

            CALC: begin
                res_data_d  = sh_out;
                res_zero_d  = (sh_out == '0);
                res_shift_d = sh_shift_q;
                state_d     = DONE;
            end

            DONE: begin
                res_valid = 1'b1;
                // A new request may only enter in the cycle the result leaves,
                // which keeps a single operation outstanding.
                req_ready = res_ready;
                if (res_ready) begin
                    op_count_d = op_count_q + CNTW'(1);
                    if (req_valid) begin
                        sh_in_d    = req_data;
                        sh_shift_d = req_shift;
                        state_d    = CALC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sh_in_q     <= '0;
            sh_shift_q  <= '0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b0;
            res_shift_q <= '0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            sh_in_q     <= sh_in_d;
            sh_shift_q  <= sh_shift_d;
            res_data_q  <= res_data_d;
            res_zero_q  <= res_zero_d;
            res_shift_q <= res_shift_d;
            op_count_q  <= op_count_d;
        end
    end

    assign sh_in     = sh_in_q;
    assign sh_shift  = sh_shift_q;
    assign res_data  = res_data_q;
    assign res_zero  = res_zero_q;
    assign res_shift = res_shift_q;
    assign op_count  = op_count_q;
    assign busy      = (state_q != IDLE);

endmodule
